// File: rtl/mdu_alu.sv
// rtl/mdu_alu.sv - MIPS integer ALU plus multi-cycle multiply/divide unit owning HI/LO
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   A, B, ALUop     ALU operands and function select
//   C, Zero         combinational ALU result and A==B flag
//   start, MDUop    MDU request strobe and operation (MULT/MULTU/DIV/DIVU/MTHI/MTLO)
//   busy            MDU operation in progress
//   HI, LO          architectural HI/LO registers
module mdu_alu #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUop,
  output logic [WIDTH-1:0] C,
  output logic             Zero,
  input  logic             start,
  input  logic [2:0]       MDUop,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int SW   = $clog2(WIDTH);
  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] pend_hi, pend_lo;
  logic             pend_wr;

  // ---------------- ALU ----------------
  logic [SW-1:0] shamt;
  assign shamt = A[SW-1:0];
  assign Zero  = (A == B);

  always_comb begin
    C = '0;
    case (ALUop)
      4'd0:  C = A + B;
      4'd1:  C = A - B;
      4'd2:  C = A & B;
      4'd3:  C = A | B;
      4'd4:  C = B << (WIDTH / 2);
      4'd5:  C = A ^ B;
      4'd6:  C = ~(A | B);
      4'd7:  C = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      4'd8:  C = {{(WIDTH-1){1'b0}}, (A < B)};
      4'd9:  C = B << shamt;
      4'd10: C = B >> shamt;
      4'd11: C = $signed(B) >>> shamt;
      default: C = '0;
    endcase
  end

  // ---------------- MDU arithmetic ----------------
  // Both products are formed at full 2*WIDTH width so the low half of the
  // unsigned multiply of sign-extended operands is the signed product.
  logic [2*WIDTH-1:0] a_sx, b_sx, a_zx, b_zx, prod_s, prod_u;
  assign a_sx   = {{WIDTH{A[WIDTH-1]}}, A};
  assign b_sx   = {{WIDTH{B[WIDTH-1]}}, B};
  assign a_zx   = {{WIDTH{1'b0}}, A};
  assign b_zx   = {{WIDTH{1'b0}}, B};
  assign prod_s = a_sx * b_sx;
  assign prod_u = a_zx * b_zx;

  // Signed division works on magnitudes; the most-negative dividend has a
  // magnitude of exactly 2^(WIDTH-1), which still fits unsigned WIDTH bits,
  // so the -2^(WIDTH-1)/-1 case naturally yields LO=-2^(WIDTH-1), HI=0.
  logic [WIDTH-1:0] abs_a, abs_b, b_safe, abs_b_safe;
  logic [WIDTH-1:0] uq_s, ur_s, sq, sr, uq, ur;
  assign abs_a      = A[WIDTH-1] ? (~A + 1'b1) : A;
  assign abs_b      = B[WIDTH-1] ? (~B + 1'b1) : B;
  assign b_safe     = (B == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : B;
  assign abs_b_safe = (B == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : abs_b;
  assign uq_s       = abs_a / abs_b_safe;
  assign ur_s       = abs_a % abs_b_safe;
  assign sq         = (A[WIDTH-1] ^ B[WIDTH-1]) ? (~uq_s + 1'b1) : uq_s;
  assign sr         = A[WIDTH-1] ? (~ur_s + 1'b1) : ur_s;
  assign uq         = A / b_safe;
  assign ur         = A % b_safe;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && (MDUop <= 3'd3)) state_next = RUN;
      RUN:     if (cnt <= CW'(1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
  end

  // ---------------- MDU datapath ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
      HI      <= '0;
      LO      <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        case (MDUop)
          3'd0: begin
            {pend_hi, pend_lo} <= prod_s;
            pend_wr <= 1'b1;
            cnt     <= CW'(MUL_CYCLES);
          end
          3'd1: begin
            {pend_hi, pend_lo} <= prod_u;
            pend_wr <= 1'b1;
            cnt     <= CW'(MUL_CYCLES);
          end
          3'd2: begin
            pend_hi <= sr;
            pend_lo <= sq;
            pend_wr <= (B != '0);   // divide by zero leaves HI/LO untouched
            cnt     <= CW'(DIV_CYCLES);
          end
          3'd3: begin
            pend_hi <= ur;
            pend_lo <= uq;
            pend_wr <= (B != '0);
            cnt     <= CW'(DIV_CYCLES);
          end
          3'd4:    HI <= A;
          3'd5:    LO <= A;
          default: ;
        endcase
      end
    end else begin
      if (cnt <= CW'(1)) begin
        cnt <= '0;
        if (pend_wr) begin
          HI <= pend_hi;
          LO <= pend_lo;
        end
      end else begin
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: doc/mdu_alu.md
# mdu_alu

Parametrised execution unit for the multi-cycle MIPS datapath. It combines a combinational integer ALU with a sequential multiply/divide unit (MDU) that owns the HI/LO registers. ALU results are available in the same cycle. MULT/DIV operations run for a programmable number of cycles under a start/busy handshake, so the pipeline stall logic can hold dependent instructions.

## Interface
- WIDTH, 32, datapath width; even, ≥ 8
- MUL_CYCLES, 5, busy duration of MULT/MULTU; ≥ 1
- DIV_CYCLES, 10, busy duration of DIV/DIVU; ≥ 1

- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- A  input  WIDTH  operand A (rs)
- B  input  WIDTH  operand B (rt or extended immediate)
- ALUop  input  4  combinational ALU function select
- C  output  WIDTH  ALU result (combinational)
- Zero  output  1  A == B (combinational)
- start  input  1  MDU request strobe, qualified by MDUop
- MDUop  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6–7 no-op
- busy  output  1  MDU operation in progress (registered)
- HI  output  WIDTH  HI register (registered)
- LO  output  WIDTH  LO register (registered)

## Operation
- ALUop encoding (all results are WIDTH bits and wrap):
  - 0 ADD: A+B
  - 1 SUB: A−B
  - 2 AND
  - 3 OR
  - 4 LUI: B << (WIDTH/2)
  - 5 XOR
  - 6 NOR
  - 7 SLT: signed A<B → 1, else 0
  - 8 SLTU: unsigned compare, same result encoding
  - 9 SLL: B << A[log2(WIDTH)-1:0]
  - 10 SRL: logical right shift, same amount
  - 11 SRA: arithmetic right shift, same amount
  - 12–15: C = 0
- MDU states:
  - IDLE
  - RUN, with counter cnt
- IDLE, start=1:
  - MULT/MULTU: compute the 2·WIDTH-bit signed/unsigned product of A and B into pending registers; cnt ← MUL_CYCLES; go to RUN.
  - DIV/DIVU: compute signed/unsigned quotient and remainder into pending registers; cnt ← DIV_CYCLES; go to RUN.
  - MTHI: HI ← A at this edge; stay IDLE; busy stays 0.
  - MTLO: LO ← A at this edge; stay IDLE; busy stays 0.
  - 6–7: ignored.
- RUN: cnt decrements each cycle. On the edge where cnt reaches 0, commit the pending result to HI/LO and return to IDLE.
  - Product: HI ← upper WIDTH bits, LO ← lower WIDTH bits.
  - Division: LO ← quotient, truncated toward zero; HI ← remainder, with the sign of the dividend.
- Divide by zero: the full DIV_CYCLES busy period still occurs; HI and LO are left unchanged at commit.
- Signed overflow, −2^(WIDTH−1) / −1: LO = −2^(WIDTH−1), HI = 0.
- A and B are sampled only on the start edge; later operand changes do not affect the running result.
- start while busy (including MTHI/MTLO): ignored entirely. The stall logic must not issue it.
- Reset, including mid-RUN: state IDLE, busy=0, HI=0, LO=0, cnt=0, pending registers 0. The in-flight result is discarded.

## Timing
- C and Zero: zero latency, purely combinational from A, B, ALUop.
- Start accepted at edge t: busy is high from t through t+N, i.e. exactly N cycles, N = MUL_CYCLES or DIV_CYCLES.
- HI/LO hold their old values while busy. They show the new result in the same cycle busy falls (edge t+N).
- A new start may be asserted in the cycle busy is low, giving back-to-back operations with no idle gap.
- MTHI/MTLO: one-edge latency; the value is visible on HI/LO the cycle after start.
- Outputs immediately after reset: busy=0, HI=0, LO=0. C and Zero follow their inputs.

## Test plan
- ALU sweep at WIDTH=32: ADD 0x7FFFFFFF+1 → 0x80000000.
- SUB 0−1 → 0xFFFFFFFF.
- SLT −1<1 → 1; SLTU 0xFFFFFFFF<1 → 0.
- SRA 0x80000000 by 4 → 0xF8000000.
- LUI B=0x1234 → 0x12340000.
- MULT A=−3, B=7 → busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULTU of the same operands → HI=0x00000006, LO=0xFFFFFFEB.
- DIV A=−7, B=2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 → busy for 10 cycles, HI/LO unchanged.
- MTLO 0xDEADBEEF while idle → LO updated next cycle, busy never asserted. MTHI issued during a running MULT → ignored; MULT result commits normally.
- Reset asserted asynchronously mid-DIV (cycle 4) → busy, HI, LO drop to 0 without waiting for a clock edge. Next DIV runs the full count from scratch.
- Parameter variant: WIDTH=16, MUL_CYCLES=1, DIV_CYCLES=1 → back-to-back MULTs with busy pulsing one cycle each; LUI shifts by 8.
